// File: rtl/avalon_master_pkg.sv
// avalon_master_pkg
//   Shared definitions for the Avalon-MM burst initiator:
//   - avm_state_t : command FSM states
//   - max_burst() : largest burst expressible in a burstcount field of the
//                   given width (top bit set, all lower bits clear)
package avalon_master_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_WR_BURST
  } avm_state_t;

  function automatic int unsigned max_burst(input int unsigned burstcount_w);
    return 32'd1 << (burstcount_w - 32'd1);
  endfunction

endpackage

// File: rtl/avalon_burst_master.sv
// avalon_burst_master
//   Avalon-MM burst initiator. Takes one read or write command at a time and
//   runs it as a single Avalon burst.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_write/cmd_address/cmd_len : direction, byte address, length in words
//   wr_data/wr_valid/wr_ready   : write beat stream (valid/ready)
//   rd_data/rd_valid            : read beat stream (no backpressure)
//   done                        : one-cycle completion pulse
//   address/burstcount/byteenable/read/write/writedata : Avalon request side
//   readdata/readdatavalid/waitrequest                 : Avalon response side
module avalon_burst_master
  import avalon_master_pkg::*;
#(
  parameter int unsigned DATA_BYTES   = 4,
  parameter int unsigned BURSTCOUNT_W = 6,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_address,
  input  logic [BURSTCOUNT_W-1:0]   cmd_len,
  input  logic [8*DATA_BYTES-1:0]   wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [8*DATA_BYTES-1:0]   rd_data,
  output logic                      rd_valid,
  output logic                      done,
  output logic [ADDR_W-1:0]         address,
  output logic [BURSTCOUNT_W-1:0]   burstcount,
  output logic [DATA_BYTES-1:0]     byteenable,
  output logic                      read,
  output logic                      write,
  output logic [8*DATA_BYTES-1:0]   writedata,
  input  logic [8*DATA_BYTES-1:0]   readdata,
  input  logic                      readdatavalid,
  input  logic                      waitrequest
);

  localparam int unsigned DATA_W   = 8 * DATA_BYTES;
  localparam int unsigned ADDR_LSB = $clog2(DATA_BYTES);
  localparam logic [BURSTCOUNT_W-1:0] MAX_BURST = BURSTCOUNT_W'(max_burst(BURSTCOUNT_W));
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((64'd1 << ADDR_LSB) - 64'd1);
  localparam logic [BURSTCOUNT_W-1:0] ONE = BURSTCOUNT_W'(1);

  avm_state_t              r_state;
  logic [BURSTCOUNT_W-1:0] r_load;       // write beats not yet taken from wr_*
  logic [BURSTCOUNT_W-1:0] r_rem;        // beats not yet completed on the bus
  logic [BURSTCOUNT_W-1:0] r_burstcount;
  logic [ADDR_W-1:0]       r_address;
  logic [DATA_BYTES-1:0]   r_byteenable;
  logic                    r_read;
  logic                    r_write;
  logic                    r_done;
  logic                    r_rd_valid;
  logic [DATA_W-1:0]       r_writedata;
  logic [DATA_W-1:0]       r_rd_data;

  logic [BURSTCOUNT_W-1:0] w_len_eff;
  logic                    w_cmd_ready;
  logic                    w_accept;
  logic                    w_wr_ready;
  logic                    w_load;
  logic                    w_consume;

  always_comb begin
    w_len_eff = cmd_len;
    if (cmd_len > MAX_BURST) w_len_eff = MAX_BURST;
  end

  // Ready is held low while reset is asserted and during the done cycle, so
  // the next command is taken no earlier than the cycle after done.
  assign w_cmd_ready = !reset && (r_state == S_IDLE) && !r_done;
  assign w_accept    = cmd_valid && w_cmd_ready;

  // One-entry output register: it may be refilled in the same cycle that
  // its current beat is consumed by the slave.
  assign w_wr_ready  = (r_state == S_WR_BURST) && (r_load != '0) &&
                       (!r_write || !waitrequest);
  assign w_load      = wr_valid && w_wr_ready;
  assign w_consume   = r_write && !waitrequest;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_load       <= '0;
      r_rem        <= '0;
      r_burstcount <= '0;
      r_address    <= '0;
      r_byteenable <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_done       <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_writedata  <= '0;
      r_rd_data    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_len_eff == '0) begin
              r_done <= 1'b1;
            end else begin
              r_address    <= cmd_address & ADDR_MASK;
              r_burstcount <= w_len_eff;
              r_byteenable <= '1;
              r_rem        <= w_len_eff;
              if (cmd_write) begin
                r_load  <= w_len_eff;
                r_state <= S_WR_BURST;
              end else begin
                r_read  <= 1'b1;
                r_state <= S_RD_REQ;
              end
            end
          end
        end
        S_RD_REQ: begin
          if (!waitrequest) begin
            r_read  <= 1'b0;
            r_state <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (readdatavalid) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= readdata;
            r_rem      <= r_rem - ONE;
            if (r_rem == ONE) begin
              r_done       <= 1'b1;
              r_state      <= S_IDLE;
              r_address    <= '0;
              r_burstcount <= '0;
              r_byteenable <= '0;
            end
          end
        end
        S_WR_BURST: begin
          if (w_load) begin
            r_writedata <= wr_data;
            r_write     <= 1'b1;
            r_load      <= r_load - ONE;
          end else if (w_consume) begin
            r_write <= 1'b0;
          end
          if (w_consume) begin
            r_rem <= r_rem - ONE;
            if (r_rem == ONE) begin
              r_done       <= 1'b1;
              r_state      <= S_IDLE;
              r_address    <= '0;
              r_burstcount <= '0;
              r_byteenable <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = w_cmd_ready;
  assign wr_ready   = w_wr_ready;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign done       = r_done;
  assign address    = r_address;
  assign burstcount = r_burstcount;
  assign byteenable = r_byteenable;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_writedata;

endmodule

// File: tb/tb_avalon_burst_master.sv
// tb_avalon_burst_master
//   Directed bench for avalon_burst_master against a behavioural Avalon
//   burst memory with optional random waitrequest / readdatavalid gaps.
module tb_avalon_burst_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_address;
  logic [5:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, done;
  logic [31:0] address;
  logic [5:0]  burstcount;
  logic [3:0]  byteenable;
  logic        read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  always #5 clk = ~clk;

  avalon_burst_master #(.DATA_BYTES(4), .BURSTCOUNT_W(6), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .address(address), .burstcount(burstcount), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest)
  );

  // ---------------- behavioural slave ----------------
  logic [31:0] mem [0:2047];
  logic [5:0]  s_wbeat;
  logic [10:0] s_raddr;
  logic [5:0]  s_rleft;
  bit          rnd  = 1'b0;
  bit          spur = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      s_wbeat       <= '0;
      s_rleft       <= '0;
      s_raddr       <= '0;
      readdatavalid <= 1'b0;
      readdata      <= '0;
      waitrequest   <= 1'b0;
    end else begin
      waitrequest   <= rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      readdatavalid <= 1'b0;
      if (write && !waitrequest) begin
        mem[address[12:2] + 11'(s_wbeat)] <= writedata;
        s_wbeat <= (s_wbeat + 6'd1 == burstcount) ? 6'd0 : s_wbeat + 6'd1;
      end
      if (read && !waitrequest) begin
        s_raddr <= address[12:2];
        s_rleft <= burstcount;
      end else if (s_rleft != 0) begin
        if (!rnd || $urandom_range(0, 1) == 1) begin
          readdatavalid <= 1'b1;
          readdata      <= mem[s_raddr];
          s_raddr       <= s_raddr + 11'd1;
          s_rleft       <= s_rleft - 6'd1;
        end
      end else if (spur) begin
        readdatavalid <= 1'b1;
        readdata      <= 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- monitor ----------------
  int unsigned m_wr_beats = 0, m_rd_beats = 0, m_done = 0, m_req = 0, m_bc_bad = 0;
  logic [5:0]  exp_bc = '0;

  always @(posedge clk) begin
    if (write && !waitrequest) m_wr_beats <= m_wr_beats + 1;
    if (rd_valid) m_rd_beats <= m_rd_beats + 1;
    if (done) m_done <= m_done + 1;
    if (read || write) begin
      m_req <= m_req + 1;
      if (burstcount !== exp_bc || byteenable !== 4'hF) m_bc_bad <= m_bc_bad + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int unsigned n_total = 0, n_pass = 0, n_fail = 0;
  logic [31:0] wbuf [0:63];
  logic [31:0] rbuf [0:63];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge following acceptance with cmd_valid dropped.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [5:0] l);
    int unsigned t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Feeds wbuf[0..n-1]; cycles = negedges from first wr_valid to done seen.
  task automatic do_write(input int unsigned n, input bit gaps,
                          output int unsigned cycles, output int unsigned loaded);
    int unsigned k = 0;
    loaded = 0;
    while (k < 1000) begin
      if (loaded < n) begin
        wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        wr_data  = wbuf[loaded];
      end else begin
        wr_valid = 1'b0;
      end
      #1;
      if (done) break;
      if (wr_valid && wr_ready) loaded++;
      @(negedge clk);
      k++;
    end
    wr_valid = 1'b0;
    cycles = k;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [5:0] l,
                         output int unsigned cnt, output bit last_with_done);
    int unsigned k = 0;
    cnt = 0;
    last_with_done = 1'b0;
    send_cmd(1'b0, a, l);
    while (k < 1000) begin
      if (rd_valid) begin
        if (cnt < 64) rbuf[cnt] = rd_data;
        cnt++;
      end
      if (done) begin
        last_with_done = rd_valid;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned cyc, ld, cnt, errs, s_done, s_wb, s_rb, s_req, s_bad;
    bit lwd;

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_len = '0; wr_data = '0; wr_valid = 1'b0;

    // Reset values
    idle(3);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_outs_zero", 64'(|{address, burstcount, byteenable, read, write,
                                   writedata, rd_data, rd_valid, done, wr_ready}), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);

    // Write 4 words at 0x40, wr_valid always high, no waitrequest
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    exp_bc = 6'd4;
    s_done = m_done; s_wb = m_wr_beats; s_bad = m_bc_bad;
    send_cmd(1'b1, 32'h40, 6'd4);
    check("wr4_address", 64'(address), 64'h40);
    check("wr4_burstcount", 64'(burstcount), 64'd4);
    do_write(4, 1'b0, cyc, ld);
    check("wr4_cycles_to_done", 64'(cyc), 64'd5);
    idle(2);
    check("wr4_beats", 64'(m_wr_beats - s_wb), 64'd4);
    check("wr4_done_once", 64'(m_done - s_done), 64'd1);
    check("wr4_bc_held", 64'(m_bc_bad - s_bad), 64'd0);

    // Read back 4 words
    s_done = m_done;
    send_cmd(1'b0, 32'h40, 6'd4);
    check("rd4_read_strobe", 64'(read), 64'd1);
    // send_cmd already waited; finish collecting via a read of the stream
    cnt = 0; lwd = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rd_valid) begin rbuf[cnt] = rd_data; cnt++; end
      if (done) begin lwd = rd_valid; break; end
      @(negedge clk);
    end
    check("rd4_count", 64'(cnt), 64'd4);
    check("rd4_done_with_last", 64'(lwd), 64'd1);
    for (int i = 0; i < 4; i++) check("rd4_data", 64'(rbuf[i]), 64'(32'hA0 + 32'(i)));
    idle(2);
    check("rd4_done_once", 64'(m_done - s_done), 64'd1);

    // len 32 write with random waitrequest and wr_valid gaps, then read
    for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
    rnd = 1'b1;
    exp_bc = 6'd32;
    s_done = m_done; s_wb = m_wr_beats; s_bad = m_bc_bad;
    send_cmd(1'b1, 32'h200, 6'd32);
    do_write(32, 1'b1, cyc, ld);
    idle(2);
    check("wr32_loaded", 64'(ld), 64'd32);
    check("wr32_beats", 64'(m_wr_beats - s_wb), 64'd32);
    check("wr32_done_once", 64'(m_done - s_done), 64'd1);
    check("wr32_bc_held", 64'(m_bc_bad - s_bad), 64'd0);
    s_done = m_done;
    do_read(32'h200, 6'd32, cnt, lwd);
    idle(2);
    errs = 0;
    for (int i = 0; i < 32; i++) if (rbuf[i] !== wbuf[i]) errs++;
    check("rd32_count", 64'(cnt), 64'd32);
    check("rd32_data_errors", 64'(errs), 64'd0);
    check("rd32_done_once", 64'(m_done - s_done), 64'd1);
    rnd = 1'b0;
    idle(2);

    // cmd_len = 0: no bus activity, done one cycle after acceptance
    s_done = m_done; s_req = m_req;
    send_cmd(1'b1, 32'h80, 6'd0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_cmd_ready_low", 64'(cmd_ready), 64'd0);
    check("len0_wr_ready", 64'(wr_ready), 64'd0);
    @(negedge clk);
    check("len0_done_drop", 64'(done), 64'd0);
    check("len0_cmd_ready_back", 64'(cmd_ready), 64'd1);
    idle(3);
    check("len0_no_req", 64'(m_req - s_req), 64'd0);
    check("len0_done_once", 64'(m_done - s_done), 64'd1);

    // cmd_len = 63 clamps to 32; unaligned address low bits ignored
    for (int i = 0; i < 40; i++) wbuf[i] = 32'h5500 + 32'(i);
    exp_bc = 6'd32;
    s_wb = m_wr_beats; s_bad = m_bc_bad;
    send_cmd(1'b1, 32'h403, 6'd63);
    check("len63_burstcount", 64'(burstcount), 64'd32);
    check("len63_address", 64'(address), 64'h400);
    do_write(40, 1'b0, cyc, ld);
    idle(2);
    check("len63_loaded", 64'(ld), 64'd32);
    check("len63_wr_beats", 64'(m_wr_beats - s_wb), 64'd32);
    check("len63_bc_held", 64'(m_bc_bad - s_bad), 64'd0);
    s_rb = m_rd_beats;
    do_read(32'h400, 6'd63, cnt, lwd);
    idle(2);
    check("len63_rd_beats", 64'(m_rd_beats - s_rb), 64'd32);
    check("len63_rd_last", 64'(rbuf[31]), 64'h551F);

    // Spurious readdatavalid while idle
    s_rb = m_rd_beats; s_done = m_done;
    spur = 1'b1;
    idle(5);
    spur = 1'b0;
    idle(2);
    check("spur_no_rd_valid", 64'(m_rd_beats - s_rb), 64'd0);
    check("spur_no_done", 64'(m_done - s_done), 64'd0);

    // Reset mid-write after 2 of 8 beats
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
    exp_bc = 6'd8;
    s_done = m_done; s_wb = m_wr_beats;
    send_cmd(1'b1, 32'h600, 6'd8);
    ld = 0;
    wr_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (m_wr_beats - s_wb >= 2) break;
      wr_data = wbuf[ld];
      #1;
      if (wr_ready) ld++;
      @(negedge clk);
    end
    check("rst_mid_two_beats", 64'(m_wr_beats - s_wb), 64'd2);
    reset = 1'b1;
    wr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_outs_zero", 64'(|{address, burstcount, byteenable, read, write,
                                       writedata, rd_data, rd_valid, done, wr_ready}), 64'd0);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    idle(4);
    check("rst_mid_no_done", 64'(m_done - s_done), 64'd0);
    exp_bc = 6'd2;
    do_read(32'h600, 6'd2, cnt, lwd);
    check("rst_mid_rd_count", 64'(cnt), 64'd2);
    check("rst_mid_word0", 64'(rbuf[0]), 64'hC0DE_0000);
    check("rst_mid_word1", 64'(rbuf[1]), 64'hC0DE_0001);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
